// File: rtl/mem_access_unit.sv
// Load/store unit with an internal word-addressed data memory, byte-lane stores,
// sign/zero-extended loads, alignment and range checking, and a single response strobe.
module mem_access_unit #(
   parameter int unsigned DEPTH  = 16384,
   parameter int unsigned RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   input  logic [2:0]  funct3,
   input  logic [31:0] alu_result,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        resp_valid,
   output logic        stall,
   output logic        misalign,
   output logic        addr_fault
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
   localparam logic [1:0]  LAT_INIT = 2'(RD_LAT - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RD_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP    = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;

   logic          is_load_q;
   logic          m2r_q;
   logic [2:0]    f3_q;
   logic [1:0]    lane_q;
   logic [31:0]   alu_q;
   logic          mis_q;
   logic          flt_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   rd_word_q;

   logic [31:0]   mem [DEPTH];

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   logic          is_byte, is_half, is_word;
   logic          is_store, is_load, is_mem;
   logic          req_misalign, req_fault, req_err;
   logic          accept, valid_load;
   logic [AW-1:0] req_idx;
   logic [3:0]    be;
   logic [31:0]   wdata;

   // Undefined size codes fall into the word class, which makes odd loads act as LW.
   assign is_byte  = (funct3[1:0] == 2'b00);
   assign is_half  = (funct3[1:0] == 2'b01);
   assign is_word  = ~is_byte & ~is_half;

   assign is_store = mem_write;
   assign is_load  = mem_read & ~mem_write;
   assign is_mem   = mem_read | mem_write;

   assign req_misalign = is_mem & ((is_half & alu_result[0]) |
                                   (is_word & (alu_result[1:0] != 2'b00)));
   assign req_fault    = is_mem & ~req_misalign &
                         ({2'b00, alu_result[31:2]} >= DEPTH_W);
   assign req_err      = req_misalign | req_fault;

   assign req_idx    = alu_result[AW+1:2];
   assign accept     = req_valid & req_ready;
   assign valid_load = is_load & ~req_err;

   always_comb begin
      be    = 4'b1111;
      wdata = data_in;
      if (is_byte) begin
         be    = 4'b0001 << alu_result[1:0];
         wdata = {4{data_in[7:0]}};
      end else if (is_half) begin
         be    = alu_result[1] ? 4'b1100 : 4'b0011;
         wdata = {2{data_in[15:0]}};
      end
   end

   // ---------------------------------------------------------------------------
   // Data memory: store at acceptance, registered read while waiting on a load
   // ---------------------------------------------------------------------------
   // NOTE: the array and its read register have no reset; contents must survive rst.
   always_ff @(posedge clk) begin
      if (accept && is_store && !req_err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[req_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (state_q == ST_RD_WAIT) rd_word_q <= mem[idx_q];
   end

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (valid_load) begin
                  state_d = ST_RD_WAIT;
                  cnt_d   = LAT_INIT;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_RD_WAIT: begin
            if (cnt_q == 2'd0) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 2'd1;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 2'd0;
         is_load_q <= 1'b0;
         m2r_q     <= 1'b0;
         f3_q      <= 3'd0;
         lane_q    <= 2'd0;
         alu_q     <= 32'd0;
         mis_q     <= 1'b0;
         flt_q     <= 1'b0;
         idx_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            is_load_q <= is_load;
            m2r_q     <= mem_to_reg;
            f3_q      <= funct3;
            lane_q    <= alu_result[1:0];
            alu_q     <= alu_result;
            mis_q     <= req_misalign;
            flt_q     <= req_fault;
            idx_q     <= req_idx;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Load extraction and response
   // ---------------------------------------------------------------------------
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;
   logic [31:0] resp_data;

   always_comb begin
      case (lane_q)
         2'd0:    ld_byte = rd_word_q[7:0];
         2'd1:    ld_byte = rd_word_q[15:8];
         2'd2:    ld_byte = rd_word_q[23:16];
         default: ld_byte = rd_word_q[31:24];
      endcase
      ld_half = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'h0, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'h0, ld_half};
         default: ld_ext = rd_word_q;
      endcase
   end

   assign resp_valid = (state_q == ST_RESP);

   always_comb begin
      resp_data = 32'd0;
      if (resp_valid && !mis_q && !flt_q) begin
         if (is_load_q) resp_data = m2r_q ? ld_ext : alu_q;
         else           resp_data = m2r_q ? 32'd0  : alu_q;
      end
   end

   assign data_out   = resp_data;
   assign misalign   = resp_valid & mis_q;
   assign addr_fault = resp_valid & flt_q;

   // rst gates the handshake outputs so nothing is offered while reset is held.
   assign req_ready = rst & (state_q == ST_IDLE);
   assign stall     = rst & ((state_q == ST_RD_WAIT) |
                             ((state_q == ST_IDLE) & req_valid & valid_load));

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed load/store vectors, error flags,
// response latency and reset abandonment of an in-flight load.
module tb_mem_access_unit;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned RD_LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic        mem_to_reg = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] alu_result = 32'd0;
   logic [31:0] data_in = 32'd0;
   logic [31:0] data_out;
   logic        resp_valid;
   logic        stall;
   logic        misalign;
   logic        addr_fault;

   mem_access_unit #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_to_reg (mem_to_reg),
      .funct3     (funct3),
      .alu_result (alu_result),
      .data_in    (data_in),
      .data_out   (data_out),
      .resp_valid (resp_valid),
      .stall      (stall),
      .misalign   (misalign),
      .addr_fault (addr_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        mis;
      logic        flt;
      int          due;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   next_id = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every response, otherwise the outputs must be quiet.
   always @(negedge clk) begin
      if (resp_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got data %08h expected no response", data_out);
         end else begin
            mon_e = sb_q.pop_front();
            check($sformatf("resp%0d_data", mon_e.id), data_out, mon_e.data);
            check($sformatf("resp%0d_misalign", mon_e.id), 32'(misalign), 32'(mon_e.mis));
            check($sformatf("resp%0d_addr_fault", mon_e.id), 32'(addr_fault), 32'(mon_e.flt));
            check($sformatf("resp%0d_cycle", mon_e.id), 32'(cyc), 32'(mon_e.due));
         end
      end else begin
         check("quiet_outputs", data_out | {30'd0, misalign, addr_fault}, 32'd0);
      end
   end

   task automatic wait_idle(input string name);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, " idle_timeout"}, 32'(req_ready), 32'd1);
   endtask

   task automatic issue(input string name, input logic rd, input logic wr, input logic m2r,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] din,
                        input logic [31:0] exp_data, input logic exp_mis, input logic exp_flt,
                        input bit poke);
      exp_t e;
      bit   vload;
      vload = rd && !wr && !exp_mis && !exp_flt;
      @(negedge clk);
      mem_read   = rd;
      mem_write  = wr;
      mem_to_reg = m2r;
      funct3     = f3;
      alu_result = addr;
      data_in    = din;
      req_valid  = 1'b1;
      #1;
      check({name, " req_ready"}, 32'(req_ready), 32'd1);
      check({name, " stall"}, 32'(stall), 32'(vload));
      e.id   = next_id;
      e.data = exp_data;
      e.mis  = exp_mis;
      e.flt  = exp_flt;
      e.due  = cyc + 1 + (vload ? RD_LAT : 0);
      sb_q.push_back(e);
      next_id++;
      @(negedge clk);
      if (vload) check({name, " stall_wait"}, 32'(stall), 32'd1);
      if (poke && vload) begin
         // A store presented while the load is pending must be ignored entirely.
         mem_read  = 1'b0;
         mem_write = 1'b1;
         data_in   = 32'hFFFF_FFFF;
         @(negedge clk);
      end
      req_valid = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      wait_idle(name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      // Reset held with a load presented: nothing may be offered or stalled.
      req_valid = 1'b1;
      mem_read  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset req_ready", 32'(req_ready), 32'd0);
      check("reset stall", 32'(stall), 32'd0);
      check("reset resp_valid", 32'(resp_valid), 32'd0);
      rst       = 1'b1;
      req_valid = 1'b0;
      mem_read  = 1'b0;
      #1;
      check("post_reset req_ready", 32'(req_ready), 32'd1);

      //     name        rd    wr    m2r   f3      addr          din           expected      mis   flt   poke
      issue("sw_dead",   1'b0, 1'b1, 1'b0, 3'b010, 32'h10,       32'hDEADBEEF, 32'h10,       1'b0, 1'b0, 1'b0);
      issue("lw_dead",   1'b1, 1'b0, 1'b1, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      issue("sb_80",     1'b0, 1'b1, 1'b1, 3'b000, 32'h13,       32'h12345680, 32'h0,        1'b0, 1'b0, 1'b0);
      issue("lb_13",     1'b1, 1'b0, 1'b1, 3'b000, 32'h13,       32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 1'b0);
      issue("lbu_13",    1'b1, 1'b0, 1'b1, 3'b100, 32'h13,       32'h0,        32'h00000080, 1'b0, 1'b0, 1'b0);
      issue("lw_10a",    1'b1, 1'b0, 1'b1, 3'b010, 32'h10,       32'h0,        32'h80ADBEEF, 1'b0, 1'b0, 1'b0);
      issue("lh_12",     1'b1, 1'b0, 1'b1, 3'b001, 32'h12,       32'h0,        32'hFFFF80AD, 1'b0, 1'b0, 1'b0);
      issue("lh_11_mis", 1'b1, 1'b0, 1'b1, 3'b001, 32'h11,       32'h0,        32'h0,        1'b1, 1'b0, 1'b0);
      issue("sw_12_mis", 1'b0, 1'b1, 1'b1, 3'b010, 32'h12,       32'h1,        32'h0,        1'b1, 1'b0, 1'b0);
      issue("lw_10b",    1'b1, 1'b0, 1'b1, 3'b010, 32'h10,       32'h0,        32'h80ADBEEF, 1'b0, 1'b0, 1'b0);
      issue("sw_0",      1'b0, 1'b1, 1'b0, 3'b010, 32'h0,        32'h11111111, 32'h0,        1'b0, 1'b0, 1'b0);
      issue("lw_40_flt", 1'b1, 1'b0, 1'b1, 3'b010, 32'h40,       32'h0,        32'h0,        1'b0, 1'b1, 1'b0);
      issue("sw_40_flt", 1'b0, 1'b1, 1'b1, 3'b010, 32'h40,       32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 1'b0);
      issue("lw_0a",     1'b1, 1'b0, 1'b1, 3'b010, 32'h0,        32'h0,        32'h11111111, 1'b0, 1'b0, 1'b0);
      issue("lw_41_pri", 1'b1, 1'b0, 1'b1, 3'b010, 32'h41,       32'h0,        32'h0,        1'b1, 1'b0, 1'b0);
      issue("alu_1234",  1'b0, 1'b0, 1'b0, 3'b010, 32'h1234,     32'h0,        32'h1234,     1'b0, 1'b0, 1'b0);
      issue("alu_m2r",   1'b0, 1'b0, 1'b1, 3'b010, 32'h1235,     32'h0,        32'h0,        1'b0, 1'b0, 1'b0);
      issue("alu_high",  1'b0, 1'b0, 1'b0, 3'b001, 32'hFFFFFFF1, 32'h0,        32'hFFFFFFF1, 1'b0, 1'b0, 1'b0);
      issue("sh_2",      1'b0, 1'b1, 1'b1, 3'b001, 32'h2,        32'hAAAABEEF, 32'h0,        1'b0, 1'b0, 1'b0);
      issue("lh_2",      1'b1, 1'b0, 1'b1, 3'b001, 32'h2,        32'h0,        32'hFFFFBEEF, 1'b0, 1'b0, 1'b0);
      issue("lhu_2",     1'b1, 1'b0, 1'b1, 3'b101, 32'h2,        32'h0,        32'h0000BEEF, 1'b0, 1'b0, 1'b0);
      issue("l011_0",    1'b1, 1'b0, 1'b1, 3'b011, 32'h0,        32'h0,        32'hBEEF1111, 1'b0, 1'b0, 1'b0);
      issue("l110_0",    1'b1, 1'b0, 1'b1, 3'b110, 32'h0,        32'h0,        32'hBEEF1111, 1'b0, 1'b0, 1'b0);
      issue("sb_1",      1'b0, 1'b1, 1'b1, 3'b000, 32'h1,        32'hFFFFFF77, 32'h0,        1'b0, 1'b0, 1'b0);
      issue("lb_1",      1'b1, 1'b0, 1'b1, 3'b000, 32'h1,        32'h0,        32'h00000077, 1'b0, 1'b0, 1'b0);
      issue("lh_0",      1'b1, 1'b0, 1'b1, 3'b001, 32'h0,        32'h0,        32'h00007711, 1'b0, 1'b0, 1'b0);
      issue("lw_0b",     1'b1, 1'b0, 1'b1, 3'b010, 32'h0,        32'h0,        32'hBEEF7711, 1'b0, 1'b0, 1'b0);
      issue("lw_m2r0",   1'b1, 1'b0, 1'b0, 3'b010, 32'h4,        32'h0,        32'h4,        1'b0, 1'b0, 1'b0);
      issue("rw_store",  1'b1, 1'b1, 1'b1, 3'b010, 32'h8,        32'h55,       32'h0,        1'b0, 1'b0, 1'b0);
      issue("lw_8_poke", 1'b1, 1'b0, 1'b1, 3'b010, 32'h8,        32'h0,        32'h55,       1'b0, 1'b0, 1'b1);
      issue("lw_8",      1'b1, 1'b0, 1'b1, 3'b010, 32'h8,        32'h0,        32'h55,       1'b0, 1'b0, 1'b0);

      // Load abandoned by reset while waiting on the array.
      @(negedge clk);
      mem_read   = 1'b1;
      mem_to_reg = 1'b1;
      funct3     = 3'b010;
      alu_result = 32'h10;
      req_valid  = 1'b1;
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_abort resp_valid", 32'(resp_valid), 32'd0);
      check("rst_abort data_out", data_out, 32'd0);
      check("rst_abort stall", 32'(stall), 32'd0);
      check("rst_abort req_ready", 32'(req_ready), 32'd0);
      repeat (4) @(negedge clk);
      check("rst_hold stall", 32'(stall), 32'd0);
      rst       = 1'b1;
      req_valid = 1'b0;
      mem_read  = 1'b0;
      wait_idle("rst_release");
      issue("lw_after_rst", 1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 1'b0, 1'b0);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
